spi_tx_arbiter: RTL and testbench

Round-robin arbiter and byte sequencer that shares one SPI output serializer among NREQ hash-table lanes. Each lane offers bytes over a valid/ready handshake, marking the final byte of a message with last. The block grants one lane, locks the grant for that lane's whole message, and issues each byte to the serializer with a start pulse. It waits for the serializer's done pulse, enforces a minimum idle gap between bytes and recovers from a hung serializer by timeout.

---
 rtl/spi_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that locks one lane per message and feeds its bytes to a
// shared SPI serializer, with an inter-byte idle gap and a hung-serializer timeout.
module spi_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_done,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    err_timeout,
    output logic [$clog2(NREQ)-1:0] err_src
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   owner_reg;
    logic [NREQ-1:0] grant_reg;
    logic [7:0]      tx_data_reg;
    logic            tx_start_reg;
    logic [IW-1:0]   err_src_reg;
    logic [TW-1:0]   timer_reg;
    logic [GW-1:0]   gap_reg;
    logic            last_q_reg;
    logic            rel_reg;

    logic            accept;
    logic            wait_end;
    logic            release_msg;
    logic            timeout_hit;
    logic [IW-1:0]   win_idx;
    logic [IW:0]     cand;
    logic [7:0]      lane_byte [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane_byte[gi] = req_data[8*gi +: 8];
            assign req_ready[gi] = (state_reg == SEND) && (owner_reg == IW'(gi)) && req_valid[gi];
        end
    endgenerate

    // Scan from the farthest offset down so the lane closest to ptr overwrites last.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (req_valid[cand[IW-1:0]]) begin
                win_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        wait_end    = 1'b0;
        release_msg = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (req_valid[owner_reg]) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A done pulse on the final timer cycle still counts as success.
                if (tx_done) begin
                    wait_end    = 1'b1;
                    release_msg = last_q_reg;
                    state_next  = GAP;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    wait_end    = 1'b1;
                    release_msg = 1'b1;
                    timeout_hit = 1'b1;
                    state_next  = GAP;
                end
            end
            GAP: begin
                if (gap_reg == GW'(GAP_CYCLES - 1)) begin
                    state_next = rel_reg ? IDLE : SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            grant_reg    <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            err_src_reg  <= '0;
            timer_reg    <= '0;
            gap_reg      <= '0;
            last_q_reg   <= 1'b0;
            rel_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_start_reg <= accept;
            if (state_reg == IDLE && |req_valid) begin
                owner_reg <= win_idx;
                grant_reg <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            end
            if (accept) begin
                tx_data_reg <= lane_byte[owner_reg];
                last_q_reg  <= req_last[owner_reg];
                timer_reg   <= '0;
            end else if (state_reg == WAIT) begin
                timer_reg <= timer_reg + TW'(1);
            end
            if (wait_end) begin
                rel_reg <= release_msg;
                gap_reg <= '0;
            end else if (state_reg == GAP) begin
                gap_reg <= gap_reg + GW'(1);
            end
            if (release_msg) begin
                grant_reg <= '0;
                ptr_reg   <= (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + IW'(1);
            end
            if (timeout_hit) begin
                err_src_reg <= owner_reg;
            end
        end
    end

    assign tx_data     = tx_data_reg;
    assign tx_start    = tx_start_reg;
    assign grant       = grant_reg;
    assign busy        = (state_reg != IDLE);
    assign err_timeout = timeout_hit;
    assign err_src     = err_src_reg;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Randomized bench: lanes hold preloaded byte streams, a serializer model answers
// starts with random delays or hangs, and a message-level model predicts every output.
module tb_spi_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int GAP     = 2;
    localparam int BIG     = 1 << 30;
    localparam int MAXCYC  = 20000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done = 1'b0;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              err_timeout;
    logic [1:0]        err_src;

    always #5 clk = ~clk;

    spi_tx_arbiter #(
        .NREQ       (NREQ),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .grant       (grant),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_src     (err_src)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Per-lane byte streams: bit 8 marks the final byte of a message.
    logic [8:0] lane_mem [NREQ][32];
    int head [NREQ];
    int tail [NREQ];

    int ptr_m       = 0;
    int owner_m     = 0;
    int exp_start   = -1;
    int grant_on    = -1;
    int idle_from   = 0;
    int done_cyc    = -1;
    int to_cyc      = -1;
    int rst_cyc     = -1;
    int exp_err_src = 0;
    logic [NREQ-1:0] exp_grant = '0;
    logic [7:0]      exp_txd = '0;
    bit cur_last   = 1'b0;
    bit in_wait    = 1'b0;
    bit reset_done = 1'b0;
    bit finished   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int lane);
        logic [NREQ-1:0] v;
        v = '0;
        v[lane] = 1'b1;
        return v;
    endfunction

    function automatic int pick_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (head[(ptr_m + k) % NREQ] < tail[(ptr_m + k) % NREQ]) begin
                return (ptr_m + k) % NREQ;
            end
        end
        return -1;
    endfunction

    // decide: the cycle the arbiter sits in IDLE looking at the lanes.
    task automatic sched_new(input int decide);
        int w;
        w = pick_winner();
        if (w >= 0) begin
            owner_m   = w;
            grant_on  = decide + 1;
            exp_start = decide + 2;
        end else begin
            grant_on  = -1;
            exp_start = -1;
        end
    endtask

    task automatic release_at(input int d);
        exp_grant = '0;
        ptr_m     = (owner_m + 1) % NREQ;
        idle_from = d + GAP + 1;
        sched_new(d + GAP + 1);
    endtask

    initial begin
        int nmsg;
        int nbyte;
        int left;
        int r;
        for (int l = 0; l < NREQ; l++) begin
            head[l] = 0;
            tail[l] = 0;
            nmsg = $urandom_range(1, 5);
            for (int m = 0; m < nmsg; m++) begin
                nbyte = $urandom_range(1, 3);
                for (int b = 0; b < nbyte; b++) begin
                    lane_mem[l][tail[l]] = {(b == nbyte - 1), 8'($urandom_range(0, 255))};
                    tail[l]++;
                end
            end
        end

        while (!finished && cyc < MAXCYC) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == grant_on) begin
                exp_grant = onehot(owner_m);
                idle_from = BIG;
            end
            rst = (cyc <= 3) || (cyc == rst_cyc);
            for (int l = 0; l < NREQ; l++) begin
                if (head[l] < tail[l]) begin
                    req_valid[l]       = 1'b1;
                    req_data[8*l +: 8] = lane_mem[l][head[l]][7:0];
                    req_last[l]        = lane_mem[l][head[l]][8];
                end else begin
                    req_valid[l]       = 1'b0;
                    req_data[8*l +: 8] = 8'h00;
                    req_last[l]        = 1'b0;
                end
            end
            // Stray done pulses outside WAIT must be ignored by the arbiter.
            tx_done = !rst && ((cyc == done_cyc) || (!in_wait && $urandom_range(0, 7) == 0));
            #1;

            check("tx_start",    32'(tx_start),    32'(cyc == exp_start));
            check("req_ready",   32'(req_ready),   32'((cyc == exp_start - 1) ? onehot(owner_m) : '0));
            check("grant",       32'(grant),       32'(exp_grant));
            check("busy",        32'(busy),        32'(cyc < idle_from));
            check("err_timeout", 32'(err_timeout), 32'(cyc == to_cyc));
            check("err_src",     32'(err_src),     32'(exp_err_src));
            check("tx_data",     32'(tx_data),     32'(exp_txd));

            if (rst) begin
                ptr_m       = 0;
                exp_grant   = '0;
                exp_txd     = '0;
                exp_err_src = 0;
                done_cyc    = -1;
                to_cyc      = -1;
                in_wait     = 1'b0;
                idle_from   = cyc + 1;
                sched_new(cyc + 1);
            end else if (cyc == exp_start - 1) begin
                exp_txd  = lane_mem[owner_m][head[owner_m]][7:0];
                cur_last = lane_mem[owner_m][head[owner_m]][8];
                head[owner_m]++;
                in_wait = 1'b1;
            end else if (cyc == exp_start) begin
                $display("[TB] start cyc=%0d lane=%0d data=%02h last=%0b", cyc, owner_m, exp_txd, cur_last);
                exp_start = -1;
                r = $urandom_range(0, 9);
                if (!reset_done && cyc > 300 && !cur_last) begin
                    // Reset lands in WAIT of a byte that is not the message's last.
                    reset_done = 1'b1;
                    done_cyc   = cyc + 8;
                    to_cyc     = -1;
                    rst_cyc    = cyc + 3;
                end else if (r == 0) begin
                    done_cyc = -1;
                    to_cyc   = cyc + TIMEOUT - 1;
                end else if (r == 1) begin
                    done_cyc = cyc + TIMEOUT - 1;
                    to_cyc   = -1;
                end else begin
                    done_cyc = cyc + $urandom_range(1, 12);
                    to_cyc   = -1;
                end
            end else if (cyc == done_cyc) begin
                in_wait  = 1'b0;
                done_cyc = -1;
                if (cur_last) begin
                    release_at(cyc);
                end else begin
                    exp_start = cyc + GAP + 2;
                end
            end else if (cyc == to_cyc) begin
                $display("[TB] timeout cyc=%0d lane=%0d", cyc, owner_m);
                in_wait     = 1'b0;
                to_cyc      = -1;
                exp_err_src = owner_m;
                release_at(cyc);
            end

            if (cyc > 3 && exp_start < 0 && done_cyc < 0 && to_cyc < 0 &&
                idle_from != BIG && cyc > idle_from + 4) begin
                finished = 1'b1;
            end
        end

        left = 0;
        for (int l = 0; l < NREQ; l++) begin
            left += tail[l] - head[l];
        end
        check("bytes_left", 32'(left), 32'(0));
        check("run_finished", 32'(finished), 32'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
